dmem_arbiter: RTL and testbench

//  Shares the single DataMemory port of the MEM stage between the pipeline (port A, priority)
//  and a debug/loader requester (port B, req/ack). Sits between MEM-stage control and DataMemory.

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared state encoding and sizing helper for the DataMemory
//                port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Arbiter states: B idle, B request captured and waiting, B ack pulse
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  // Width of the B wait counter; at least one bit even when MAX_WAIT is 0
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single DataMemory port between the MEM-stage
//                pipeline (port A, priority) and a req/ack debug/loader
//                requester (port B). B is served when A is idle, or forces a
//                one-cycle pipeline stall after MAX_WAIT denied cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  // Port A: pipeline MEM stage
  input  logic [ADDR_W-1:0] memaddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              memread_a,
  input  logic              memwrite_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              stall_a,
  // Port B: debug/loader requester
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  // DataMemory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W      = cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  logic w_a_active;
  logic w_grant_b;

  // B owns the port when pending and either A is idle or B has waited long enough
  always_comb begin
    w_a_active = memread_a | memwrite_a;
    w_grant_b  = (state_q == ST_PEND) &&
                 (!w_a_active || (wait_cnt_q == C_MAX_WAIT));
  end

  // Next-state logic: capture B request, count denied cycles, latch read data
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_b_d  = rdata_b_q;
    case (state_q)
      ST_IDLE: begin
        if (req_b) begin
          we_d       = we_b;
          addr_d     = addr_b;
          wdata_d    = wdata_b;
          wait_cnt_d = '0;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_grant_b) begin
          if (!we_q) begin
            rdata_b_d = mem_rdata;
          end
          state_d = ST_ACK;
        end else begin
          // Grant is forced at C_MAX_WAIT, so the count never passes it
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      // Request level seen here belongs to the completed access; ignore it
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any pending B request without touching memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  // Port mux: granted B drives memory, otherwise A passes straight through
  always_comb begin
    mem_addr  = w_grant_b ? addr_q  : memaddr_a;
    mem_wdata = w_grant_b ? wdata_q : wdata_a;
    mem_read  = w_grant_b ? !we_q   : memread_a;
    mem_write = w_grant_b ? we_q    : memwrite_a;
    stall_a   = w_grant_b & w_a_active;
    rdata_a   = mem_rdata;
    ack_b     = (state_q == ST_ACK);
    rdata_b   = rdata_b_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a transaction-level
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memaddr_a, wdata_a, rdata_a;
  logic        memread_a, memwrite_a, stall_a;
  logic        req_b, we_b, ack_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .memaddr_a(memaddr_a), .wdata_a(wdata_a), .memread_a(memread_a),
    .memwrite_a(memwrite_a), .rdata_a(rdata_a), .stall_a(stall_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // DataMemory: asynchronous read, synchronous write, 256 words
  logic [31:0] dmem [256] = '{default: 32'h0};
  assign mem_rdata = dmem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) dmem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_mem [256] = '{default: 32'h0};
  bit          m_pend, m_ackdue, m_we;
  int          m_wait;
  logic [31:0] m_addr, m_wdata, m_rdata_b;
  bit          a_act, e_grant, e_rd, e_wr, e_stall, e_ack;
  logic [31:0] e_addr, e_wdata, e_rdb, e_rda;

  initial begin
    m_pend = 0; m_ackdue = 0; m_we = 0; m_wait = 0;
    m_addr = 0; m_wdata = 0; m_rdata_b = 0;
  end

  // Compare process: expected outputs from current inputs and model, then advance
  always @(negedge clk) begin
    a_act   = memread_a | memwrite_a;
    e_grant = !reset && m_pend && (!a_act || m_wait >= MW);
    if (e_grant) begin
      e_addr = m_addr; e_wdata = m_wdata; e_rd = !m_we; e_wr = m_we;
    end else begin
      e_addr = memaddr_a; e_wdata = wdata_a; e_rd = memread_a; e_wr = memwrite_a;
    end
    e_stall = e_grant && a_act;
    e_ack   = !reset && m_ackdue;
    e_rdb   = reset ? 32'h0 : m_rdata_b;
    e_rda   = m_mem[e_addr[7:0]];

    chk("stall_a",   {31'b0, stall_a},   {31'b0, e_stall});
    chk("ack_b",     {31'b0, ack_b},     {31'b0, e_ack});
    chk("rdata_b",   rdata_b,            e_rdb);
    chk("mem_addr",  mem_addr,           e_addr);
    chk("mem_wdata", mem_wdata,          e_wdata);
    chk("mem_read",  {31'b0, mem_read},  {31'b0, e_rd});
    chk("mem_write", {31'b0, mem_write}, {31'b0, e_wr});
    chk("rdata_a",   rdata_a,            e_rda);

    if (e_wr) m_mem[e_addr[7:0]] = e_wdata;
    if (reset) begin
      m_pend = 0; m_ackdue = 0; m_wait = 0; m_rdata_b = 0;
    end else if (m_ackdue) begin
      m_ackdue = 0;
    end else if (m_pend) begin
      if (e_grant) begin
        if (!m_we) m_rdata_b = e_rda;
        m_pend = 0; m_ackdue = 1;
      end else begin
        m_wait++;
      end
    end else if (req_b) begin
      m_pend = 1; m_wait = 0;
      m_we = we_b; m_addr = addr_b; m_wdata = wdata_b;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_a(input bit rd, input bit wr, input logic [31:0] ad, input logic [31:0] wd);
    memread_a = rd; memwrite_a = wr; memaddr_a = ad; wdata_a = wd;
  endtask

  task automatic set_b(input bit rq, input bit we, input logic [31:0] ad, input logic [31:0] wd);
    req_b = rq; we_b = we; addr_b = ad; wdata_b = wd;
  endtask

  initial begin
    int stall_cnt, stall_at, ack_at, ack_cnt, first_ack, second_ack, wr_cnt;
    bit ack_seen;
    reset = 1'b1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Preload [0x10]=0x1234 and [0x20]=0x5555 through port A
    set_a(0, 1, 32'h10, 32'h1234); step();
    set_a(0, 1, 32'h20, 32'h5555); step();
    set_a(0, 0, 0, 0); step();

    // B read of 0x10 with A idle: grant c1, ack c2
    set_b(1, 0, 32'h10, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (k == 0) chk("t2_c0_ack", {31'b0, ack_b}, 32'd0);
      if (k == 1) begin
        chk("t2_c1_read", {31'b0, mem_read}, 32'd1);
        chk("t2_c1_addr", mem_addr, 32'h10);
      end
      if (k == 2) begin
        chk("t2_c2_ack", {31'b0, ack_b}, 32'd1);
        chk("t2_c2_rdata", rdata_b, 32'h1234);
      end
      step();
    end
    set_b(0, 0, 0, 0);
    step();

    // A reads every cycle, B read: eight denied cycles, one stall, then ack
    stall_cnt = 0; stall_at = -1; ack_at = -1;
    set_b(1, 0, 32'h10, 32'h0);
    for (int k = 0; k < 14; k++) begin
      set_a(1, 0, {24'h0, 8'($urandom_range(0, 255))}, 32'h0);
      @(negedge clk); #1;
      if (stall_a) begin stall_cnt++; stall_at = k; end
      if (ack_b) begin ack_at = k; end
      step();
      if (ack_at >= 0) req_b = 1'b0;
    end
    chk("t3_stall_count", stall_cnt, 32'd1);
    chk("t3_stall_cycle", stall_at, MW + 1);
    chk("t3_ack_cycle", ack_at, MW + 2);

    // A reads 0x20 while B writes 0xDEADBEEF there via forced grant
    set_a(1, 0, 32'h20, 32'h0);
    set_b(1, 1, 32'h20, 32'hDEADBEEF);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk); #1;
      if (k == MW)     chk("t4_before", rdata_a, 32'h5555);
      if (k == MW + 1) chk("t4_stalled", {31'b0, stall_a}, 32'd1);
      if (k == MW + 2) begin
        chk("t4_retry_stall", {31'b0, stall_a}, 32'd0);
        chk("t4_retry_data", rdata_a, 32'hDEADBEEF);
      end
      step();
      if (k == MW + 2) req_b = 1'b0;
    end
    set_a(0, 0, 0, 0);
    step();

    // Reset while a B write is pending: no B write, no ack
    set_a(1, 0, 32'h40, 32'h0);
    set_b(1, 1, 32'h30, 32'hCAFEF00D);
    repeat (3) step();
    reset = 1'b1;
    req_b = 1'b0;
    @(negedge clk); #1;
    chk("t5_reset_rdata_b", rdata_b, 32'h0);
    chk("t5_reset_stall", {31'b0, stall_a}, 32'd0);
    chk("t5_reset_addr", mem_addr, 32'h40);
    step();
    reset = 1'b0;
    ack_cnt = 0; wr_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (ack_b) ack_cnt++;
      if (mem_write) wr_cnt++;
      step();
    end
    chk("t5_ack_count", ack_cnt, 32'd0);
    chk("t5_write_count", wr_cnt, 32'd0);
    chk("t5_mem30", dmem[8'h30], 32'h0);
    set_a(0, 0, 0, 0);
    step();

    // req_b held six cycles with A idle: acks at c2 and c5
    ack_cnt = 0; first_ack = -1; second_ack = -1;
    set_b(1, 0, 32'h20, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (ack_b) begin
        ack_cnt++;
        if (first_ack < 0) first_ack = k; else second_ack = k;
      end
      step();
      if (k == 5) req_b = 1'b0;
    end
    chk("t6_ack_count", ack_cnt, 32'd2);
    chk("t6_first_ack", first_ack, 32'd2);
    chk("t6_second_ack", second_ack, 32'd5);

    // Random traffic with occasional resets
    ack_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       set_a(0, 0, $urandom, $urandom);
        2:       set_a(0, 1, $urandom, $urandom);
        default: set_a(1, 0, $urandom, $urandom);
      endcase
      if (req_b && ack_seen && $urandom_range(0, 3) != 0) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 3) == 0)
        set_b(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      reset = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      ack_seen = ack_b;
      step();
    end
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
